lpc_frame_scheduler: RTL and testbench
======================================

Name: lpc_frame_scheduler

Overview:
Frame-level sequencer that sits above lpc_encode and runs it as a streaming engine. It takes audio samples from a valid/ready stream and writes them into the lpc_encode audio write channel. When a full frame is loaded it pulses start and waits for rready. It then drains the 10 LPC coefficients and the frame's residues out through a single 32-bit valid/ready output stream.

Parameters:
- FRAME_LEN, 160: samples per frame. Range 1..160.
- NCOEF, 10: coefficients per frame. Equals the width of a_rsel; range 1..10.
- START_BLANK, 2: cycles after the start pulse during which rready is ignored, so a stale high is not taken as done.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  input sample accept
- in_data  in  16  signed audio sample
- x_wen  out  1  write enable to lpc_encode audio channel
- x_waddr  out  8  write address to lpc_encode
- x_din  out  16  write data to lpc_encode
- start  out  1  one-cycle start pulse to lpc_encode
- rready  in  1  lpc_encode done/idle flag
- a_rsel  out  10  one-hot coefficient select to lpc_encode
- a_dout  in  32  coefficient read data (combinational from a_rsel)
- residue_raddr  out  8  residue read address to lpc_encode
- residue_dout  in  16  residue read data (combinational from residue_raddr)
- out_valid  out  1  output word valid
- out_ready  in  1  output word accept
- out_data  out  32  coefficient, or sign-extended residue
- out_kind  out  1  0 = coefficient, 1 = residue
- out_last  out  1  marks the final residue of the frame
- frame_cnt  out  16  frames fully drained, wraps at 2^16
- busy  out  1  high in any state other than LOAD with load count 0

Behaviour:
- Reset values: in_ready=1, start=0, x_wen=0, out_valid=0, out_last=0, a_rsel=0, residue_raddr=0, frame_cnt=0, busy=0. State goes to LOAD, all counters to 0.
- States: LOAD, START, BLANK, WAIT, DRAIN_A, DRAIN_R.
- LOAD:
  - in_ready=1.
  - Accept a sample when in_valid && in_ready. On accept: x_wen=1, x_waddr=ld_cnt, x_din=in_data (combinational, same cycle).
  - ld_cnt increments on each accept.
  - On the accept with ld_cnt==FRAME_LEN-1: clear ld_cnt and go to START.
- START:
  - start=1 for exactly one cycle; in_ready=0.
  - Next state is BLANK with blank_cnt=0.
- BLANK:
  - Count START_BLANK cycles, ignoring rready, then go to WAIT.
  - If START_BLANK=0, go directly to WAIT.
- WAIT:
  - Stay until rready==1, then go to DRAIN_A with rd_cnt=0.
  - No timeout.
- DRAIN_A:
  - out_valid=1, a_rsel=1<<rd_cnt, out_data=a_dout, out_kind=0.
  - Advance rd_cnt only on out_valid && out_ready. While stalled, a_rsel and out_data are held.
  - After the transfer of index NCOEF-1: go to DRAIN_R with rd_cnt=0.
- DRAIN_R:
  - residue_raddr=rd_cnt, out_data={{16{residue_dout[15]}},residue_dout}, out_kind=1.
  - out_last=1 when rd_cnt==FRAME_LEN-1.
  - On the transfer of the last residue: frame_cnt increments and the state returns to LOAD.
- Outside the drain states: a_rsel=0, out_valid=0.
- Back-to-back: no idle cycle between the DRAIN_A to DRAIN_R handover; the first residue is valid the cycle after the last coefficient transfer.
- Reset mid-operation (any state) takes effect next cycle:
  - All outputs return to reset values, and the partial frame is discarded.
  - No start is issued.
  - lpc_encode is not reset by this block.
- out_valid does not drop while waiting for out_ready. Words are never duplicated or skipped.

Optional Feature:
- Macro LPC_FRAME_SCHED_OVERLAP_EN.
- When defined:
  - in_ready=1 also in DRAIN_A and DRAIN_R (lpc_encode no longer reads the audio buffer once done), so the next frame's samples are written during the drain.
  - ld_cnt persists across the drain.
  - On the final transfer of a frame: if ld_cnt has already reached FRAME_LEN (full flag set), go straight to START; otherwise go to LOAD and continue from ld_cnt.
  - In the full state, in_ready=0 until the move to START.
- When undefined: in_ready=0 in all states except LOAD.

Test Plan:
- Reset, then stream ramp 0..159 with in_valid held high → x_wen on 160 cycles with x_waddr 0..159 and x_din = waddr; start high for exactly 1 cycle, the cycle after the last write; in_ready=0 afterwards.
- rready held high throughout, then low 2 cycles after start, then high 400 cycles later → no drain during BLANK; out_valid rises the cycle after rready is seen high in WAIT.
- Drain with out_ready=1 → 10 words kind=0 with a_rsel 0x001..0x200, then 160 words kind=1 with residue_raddr 0..159; out_last only on the 170th word; frame_cnt=1; in_ready=1.
- out_ready alternating 1/0 with residue_dout=16'h8000 at address 5 → exactly 170 transfers, word 16 = 32'hFFFF8000, held values stable across stalls.
- Assert reset during DRAIN_R at word 60 → next cycle out_valid=0, in_ready=1, frame_cnt=0, and no start pulse appears.
- With the macro defined, stream frame 2 during frame 1's drain → x_wen active during drain; start for frame 2 the cycle after frame 1's out_last transfer. With the macro undefined → in_ready=0 throughout the drain.

Source files
------------

// File: rtl/lpc_frame_scheduler_if.sv
// Stream and lpc_encode-side signal bundle for lpc_frame_scheduler.
// master is the scheduler's view; slave is the view of the stream source/sink and lpc_encode.
interface lpc_frame_scheduler_if #(
    parameter int NCOEF = 10
);
    // audio sample input stream
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_data;

    // lpc_encode audio write channel and control
    logic               x_wen;
    logic [7:0]         x_waddr;
    logic [15:0]        x_din;
    logic               start;
    logic               rready;

    // lpc_encode result read ports
    logic [NCOEF-1:0]   a_rsel;
    logic [31:0]        a_dout;
    logic [7:0]         residue_raddr;
    logic [15:0]        residue_dout;

    // result output stream and status
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic               out_kind;
    logic               out_last;
    logic [15:0]        frame_cnt;
    logic               busy;

    modport master (
        input  in_valid, in_data, rready, a_dout, residue_dout, out_ready,
        output in_ready, x_wen, x_waddr, x_din, start, a_rsel, residue_raddr,
               out_valid, out_data, out_kind, out_last, frame_cnt, busy
    );

    modport slave (
        output in_valid, in_data, rready, a_dout, residue_dout, out_ready,
        input  in_ready, x_wen, x_waddr, x_din, start, a_rsel, residue_raddr,
               out_valid, out_data, out_kind, out_last, frame_cnt, busy
    );
endinterface

// File: rtl/lpc_frame_scheduler.sv
// Frame sequencer driving lpc_encode: load samples, start, wait for done, drain coefs + residues.
// Define LPC_FRAME_SCHED_OVERLAP_EN to load the next frame while the current one drains.
module lpc_frame_scheduler #(
    parameter int FRAME_LEN   = 160,
    parameter int NCOEF       = 10,
    parameter int START_BLANK = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    lpc_frame_scheduler_if.master  bus
);

    typedef enum logic [2:0] {
        LOAD,
        START,
        BLANK,
        WAIT,
        DRAIN_A,
        DRAIN_R
    } state_t;

    localparam logic [7:0] LAST_SAMPLE = 8'(FRAME_LEN - 1);
    localparam logic [7:0] LAST_COEF   = 8'(NCOEF - 1);
    localparam logic [7:0] LAST_BLANK  = 8'((START_BLANK > 0) ? (START_BLANK - 1) : 0);

    state_t      state_reg, state_next;
    logic [7:0]  ld_cnt_reg, ld_cnt_next;
    logic [7:0]  blank_cnt_reg, blank_cnt_next;
    logic [7:0]  rd_cnt_reg, rd_cnt_next;
    logic [15:0] frame_cnt_reg, frame_cnt_next;
    // set when the next frame finished loading during a drain; never set without overlap
    logic        full_reg, full_next;

    logic              in_ready_c;
    logic              accept;
    logic              last_sample;
    logic              frame_ready;
    logic              start_c;
    logic              out_valid_c;
    logic              out_kind_c;
    logic              out_last_c;
    logic [31:0]       out_data_c;
    logic [7:0]        residue_raddr_c;
    logic [NCOEF-1:0]  a_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= LOAD;
            ld_cnt_reg    <= 8'd0;
            blank_cnt_reg <= 8'd0;
            rd_cnt_reg    <= 8'd0;
            frame_cnt_reg <= 16'd0;
            full_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ld_cnt_reg    <= ld_cnt_next;
            blank_cnt_reg <= blank_cnt_next;
            rd_cnt_reg    <= rd_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
            full_reg      <= full_next;
        end
    end

    always_comb begin
        in_ready_c = 1'b0;
        case (state_reg)
            LOAD:             in_ready_c = 1'b1;
`ifdef LPC_FRAME_SCHED_OVERLAP_EN
            // lpc_encode no longer reads the audio buffer once it reports done
            DRAIN_A, DRAIN_R: in_ready_c = !full_reg;
`endif
            default:          in_ready_c = 1'b0;
        endcase
    end

    assign accept      = bus.in_valid && in_ready_c;
    assign last_sample = (ld_cnt_reg == LAST_SAMPLE);
    assign frame_ready = full_reg || (accept && last_sample);

    always_comb begin
        state_next      = state_reg;
        ld_cnt_next     = ld_cnt_reg;
        blank_cnt_next  = blank_cnt_reg;
        rd_cnt_next     = rd_cnt_reg;
        frame_cnt_next  = frame_cnt_reg;
        full_next       = full_reg;
        start_c         = 1'b0;
        out_valid_c     = 1'b0;
        out_kind_c      = 1'b0;
        out_last_c      = 1'b0;
        out_data_c      = 32'd0;
        residue_raddr_c = 8'd0;

        // sample loading is shared by LOAD and (with overlap) the drain states
        if (accept) begin
            if (last_sample) begin
                ld_cnt_next = 8'd0;
                full_next   = (state_reg != LOAD);
            end else begin
                ld_cnt_next = ld_cnt_reg + 8'd1;
            end
        end

        case (state_reg)
            LOAD: begin
                if (accept && last_sample) begin
                    state_next = START;
                end
            end
            START: begin
                start_c        = 1'b1;
                blank_cnt_next = 8'd0;
                state_next     = (START_BLANK == 0) ? WAIT : BLANK;
            end
            BLANK: begin
                if (blank_cnt_reg == LAST_BLANK) begin
                    state_next = WAIT;
                end else begin
                    blank_cnt_next = blank_cnt_reg + 8'd1;
                end
            end
            WAIT: begin
                if (bus.rready) begin
                    state_next  = DRAIN_A;
                    rd_cnt_next = 8'd0;
                end
            end
            DRAIN_A: begin
                out_valid_c = 1'b1;
                out_data_c  = bus.a_dout;
                if (bus.out_ready) begin
                    if (rd_cnt_reg == LAST_COEF) begin
                        state_next  = DRAIN_R;
                        rd_cnt_next = 8'd0;
                    end else begin
                        rd_cnt_next = rd_cnt_reg + 8'd1;
                    end
                end
            end
            DRAIN_R: begin
                out_valid_c     = 1'b1;
                out_kind_c      = 1'b1;
                residue_raddr_c = rd_cnt_reg;
                out_data_c      = {{16{bus.residue_dout[15]}}, bus.residue_dout};
                out_last_c      = (rd_cnt_reg == LAST_SAMPLE);
                if (bus.out_ready) begin
                    if (rd_cnt_reg == LAST_SAMPLE) begin
                        frame_cnt_next = frame_cnt_reg + 16'd1;
                        rd_cnt_next    = 8'd0;
                        // a frame completed during the drain starts immediately
                        if (frame_ready) begin
                            state_next = START;
                            full_next  = 1'b0;
                        end else begin
                            state_next = LOAD;
                        end
                    end else begin
                        rd_cnt_next = rd_cnt_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCOEF; gi++) begin : g_a_sel
            assign a_sel[gi] = (state_reg == DRAIN_A) && (rd_cnt_reg == 8'(gi));
        end
    endgenerate

    assign bus.in_ready      = in_ready_c;
    assign bus.x_wen         = accept;
    assign bus.x_waddr       = ld_cnt_reg;
    assign bus.x_din         = bus.in_data;
    assign bus.start         = start_c;
    assign bus.a_rsel        = a_sel;
    assign bus.residue_raddr = residue_raddr_c;
    assign bus.out_valid     = out_valid_c;
    assign bus.out_data      = out_data_c;
    assign bus.out_kind      = out_kind_c;
    assign bus.out_last      = out_last_c;
    assign bus.frame_cnt     = frame_cnt_reg;
    assign bus.busy          = !((state_reg == LOAD) && (ld_cnt_reg == 8'd0));

endmodule

// File: tb/tb_lpc_frame_scheduler.sv
// Directed-plus-random bench for lpc_frame_scheduler with a word-list model of each frame.
// Expectations adapt when LPC_FRAME_SCHED_OVERLAP_EN is defined.
module tb_lpc_frame_scheduler;

    localparam int FL = 160;
    localparam int NC = 10;
    localparam int SB = 2;
`ifdef LPC_FRAME_SCHED_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lpc_frame_scheduler_if #(.NCOEF(NC)) bus ();

    lpc_frame_scheduler #(
        .FRAME_LEN  (FL),
        .NCOEF      (NC),
        .START_BLANK(SB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // lpc_encode result memories, refreshed for every frame
    logic [31:0] coef_mem [NC];
    logic [15:0] res_mem  [FL];
    logic [31:0] a_dout_m;
    logic [15:0] res_m;

    always_comb begin
        a_dout_m = 32'hBAD0_BAD0;
        for (int i = 0; i < NC; i++) begin
            if (bus.a_rsel == (NC'(1) << i)) a_dout_m = coef_mem[i];
        end
    end

    always_comb begin
        res_m = 16'h0;
        if (int'(bus.residue_raddr) < FL) res_m = res_mem[bus.residue_raddr];
    end

    assign bus.a_dout       = a_dout_m;
    assign bus.residue_dout = res_m;

    int checks      = 0;
    int failures    = 0;
    int loaded      = 0;
    int frames_done = 0;
    int nxfer;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // input-side checks at the sampling point; advances the loaded-sample model on accept
    task automatic check_input_side(input bit exp_rdy);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (exp_rdy && bus.in_valid) begin
            chk("x_wen", 32'(bus.x_wen), 32'd1);
            chk("x_waddr", 32'(bus.x_waddr), 32'(loaded));
            chk("x_din", 32'(bus.x_din), 32'(bus.in_data));
            loaded++;
        end else begin
            chk("x_wen_idle", 32'(bus.x_wen), 32'd0);
        end
    endtask

    task automatic load_rest(input bit ramp, input bit gaps);
        int cyc = 0;
        while (loaded < FL && cyc < 2000) begin
            bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = ramp ? 16'(loaded) : 16'($urandom);
            @(negedge clk);
            chk("busy_load", 32'(bus.busy), 32'(loaded != 0));
            chk("start_load", 32'(bus.start), 32'd0);
            check_input_side(1'b1);
            tick();
            cyc++;
        end
        if (loaded < FL) chk("load_timeout", 32'(loaded), 32'(FL));
        loaded = 0;
    endtask

    task automatic start_wait(input bit stale, input int wait_len);
        for (int i = 0; i < NC; i++) coef_mem[i] = $urandom;
        for (int i = 0; i < FL; i++) res_mem[i] = 16'($urandom);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'($urandom);
        bus.rready   = stale;
        @(negedge clk);
        chk("start_pulse", 32'(bus.start), 32'd1);
        chk("start_in_ready", 32'(bus.in_ready), 32'd0);
        chk("start_x_wen", 32'(bus.x_wen), 32'd0);
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("start_frame_cnt", 32'(bus.frame_cnt), 32'(frames_done));
        tick();
        for (int b = 0; b < SB; b++) begin
            bus.rready = stale;
            @(negedge clk);
            chk("blank_start", 32'(bus.start), 32'd0);
            chk("blank_valid", 32'(bus.out_valid), 32'd0);
            check_input_side(1'b0);
            tick();
        end
        bus.rready = 1'b0;
        for (int w = 0; w < wait_len; w++) begin
            @(negedge clk);
            chk("wait_valid", 32'(bus.out_valid), 32'd0);
            chk("wait_start", 32'(bus.start), 32'd0);
            tick();
        end
        bus.rready = 1'b1;
        @(negedge clk);
        chk("wait_exit_valid", 32'(bus.out_valid), 32'd0);
        tick();
    endtask

    // mode 0: out_ready high, 1: alternating, 2: random
    task automatic drain(input int mode, input int stop_after, input bit feed_all, output int n);
        int cyc = 0;
        logic [31:0] exp_data;
        logic [NC-1:0] exp_sel;
        int r;
        n = 0;
        while (n < stop_after && cyc < 5000) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 2 == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = feed_all ? 1'b1 : 1'($urandom_range(0, 1));
            bus.in_data  = 16'($urandom);
            @(negedge clk);
            chk("drain_valid", 32'(bus.out_valid), 32'd1);
            if (n < NC) begin
                exp_sel    = '0;
                exp_sel[n] = 1'b1;
                exp_data   = coef_mem[n];
                chk("coef_sel", 32'(bus.a_rsel), 32'(exp_sel));
                chk("coef_kind", 32'(bus.out_kind), 32'd0);
                chk("coef_last", 32'(bus.out_last), 32'd0);
            end else begin
                r        = n - NC;
                exp_data = 32'($signed(res_mem[r]));
                chk("res_raddr", 32'(bus.residue_raddr), 32'(r));
                chk("res_sel", 32'(bus.a_rsel), 32'd0);
                chk("res_kind", 32'(bus.out_kind), 32'd1);
                chk("res_last", 32'(bus.out_last), 32'(r == FL - 1));
            end
            chk("out_data", bus.out_data, exp_data);
            if (n == NC + 5 && res_mem[5] == 16'h8000) chk("word16_sext", bus.out_data, 32'hFFFF_8000);
            chk("drain_start", 32'(bus.start), 32'd0);
            check_input_side(OVL && (loaded < FL));
            if (bus.out_ready) n++;
            tick();
            cyc++;
        end
        if (n < stop_after) chk("drain_timeout", 32'(n), 32'(stop_after));
    endtask

    task automatic post_drain();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post_frame_cnt", 32'(bus.frame_cnt), 32'(frames_done));
        chk("post_valid", 32'(bus.out_valid), 32'd0);
        chk("post_last", 32'(bus.out_last), 32'd0);
        chk("post_sel", 32'(bus.a_rsel), 32'd0);
        chk("post_start", 32'(bus.start), 32'(loaded == FL));
        chk("post_in_ready", 32'(bus.in_ready), 32'(loaded < FL));
        chk("post_busy", 32'(bus.busy), 32'(loaded != 0));
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0;
        bus.rready    = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NC; i++) coef_mem[i] = 32'h0;
        for (int i = 0; i < FL; i++) res_mem[i] = 16'h0;
        repeat (3) tick();
        reset = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_start", 32'(bus.start), 32'd0);
        chk("rst_x_wen", 32'(bus.x_wen), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_a_rsel", 32'(bus.a_rsel), 32'd0);
        chk("rst_raddr", 32'(bus.residue_raddr), 32'd0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        tick();

        // frame 1: ramp, stale rready across blanking, long wait, full-rate drain with input held high
        load_rest(1'b1, 1'b0);
        start_wait(1'b1, 400);
        drain(0, NC + FL, 1'b1, nxfer);
        frames_done++;
        if (loaded < FL) post_drain();

        // frame 2: gapped input, alternating out_ready, negative residue at address 5
        load_rest(1'b0, 1'b1);
        start_wait(1'b0, 1 + $urandom_range(0, 20));
        res_mem[5] = 16'h8000;
        drain(1, NC + FL, 1'b0, nxfer);
        chk("frame2_xfers", 32'(nxfer), 32'(NC + FL));
        frames_done++;
        if (loaded < FL) post_drain();

        // frame 3: reset after 60 words
        load_rest(1'b0, 1'b1);
        start_wait(1'b1, 3);
        drain(2, 60, 1'b0, nxfer);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_sel", 32'(bus.a_rsel), 32'd0);
        chk("mid_rst_raddr", 32'(bus.residue_raddr), 32'd0);
        tick();
        loaded      = 0;
        frames_done = 0;
        bus.rready  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("mid_rst_no_start", 32'(bus.start), 32'd0);
            chk("mid_rst_idle", 32'(bus.out_valid), 32'd0);
            tick();
        end

        // frame 4: fully random traffic after the reset
        load_rest(1'b0, 1'b1);
        start_wait(1'b1, 1 + $urandom_range(0, 30));
        drain(2, NC + FL, 1'b0, nxfer);
        frames_done++;
        post_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
